// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU issue controller and the
// alu_operations_five execute unit.
//   - Opcode encodings ADD..MUL and OP_MAX (largest legal opcode).
//   - issue_state_t: controller FSM encoding, also exported on the debug port.
//   - lat_cnt_w(): width of a down-counter able to hold the larger latency.
package alu_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_SLT = 4;
  localparam int unsigned OP_MUL = 5;
  localparam int unsigned OP_MAX = OP_MUL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issue_state_t;

  // Bits needed to count down from max(alu_lat, mul_lat) to 1.
  function automatic int lat_cnt_w(input int alu_lat, input int mul_lat);
    int lat_max;
    lat_max = (alu_lat > mul_lat) ? alu_lat : mul_lat;
    return (lat_max < 2) ? 1 : $clog2(lat_max + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant was taken this cycle; hand priority to the loser
//   gnt[1:0]   : one-hot grant (zero when nobody requests), combinational
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic prio_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  // After granting requester 0 the tie goes to requester 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: shares one alu_operations_five unit between two requesters.
//   req_valid/req_ready[1:0]     : per-requester valid/ready request channel
//   req_a*/req_b*/req_op*        : operands and opcode of each requester
//   alu_load/alu_a/alu_b/alu_opcode : drive the ALU (load is a 1-cycle strobe)
//   alu_result                   : ALU result, sampled at the end of the wait
//   rsp_valid/rsp_ready          : response channel with backpressure
//   rsp_data/rsp_id/rsp_err      : result, issuing requester, illegal-opcode flag
//   dbg_state                    : current FSM state
//
// Handshake rule on both channels: a transfer happens at a rising clk edge
// where valid and ready are both high; the producer holds valid and its
// payload unchanged until that edge, and the payload is stable while valid.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  output logic              alu_load,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_err,
  output issue_state_t      dbg_state
);

  localparam int CNT_W = lat_cnt_w(ALU_LAT, MUL_LAT);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OP_W-1:0]  OPC_MUL = OP_W'(OP_MUL);
  localparam logic [OP_W-1:0]  OPC_MAX = OP_W'(OP_MAX);

  issue_state_t      state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        gnt;
  logic              accept;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0]   sel_op;

  // Arbiter runs every cycle, but its grant only matters while idle.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;
  assign accept    = (state_q == ST_IDLE) && (gnt != 2'b00);

  always_comb begin
    sel_a  = req_a0;
    sel_b  = req_b0;
    sel_op = req_op0;
    if (gnt[1]) begin
      sel_a  = req_a1;
      sel_b  = req_b1;
      sel_op = req_op1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      alu_load  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            op_q     <= sel_op;
            rsp_id   <= gnt[1];
            rsp_err  <= (sel_op > OPC_MAX);
            alu_load <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Illegal opcodes go to the ALU untouched and use the short latency.
          alu_load <= 1'b0;
          cnt_q    <= (op_q == OPC_MUL) ? MUL_CNT : ALU_CNT;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand registers only change on accept, so they stay stable from
  // ISSUE through the end of WAIT.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 2;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [OP_W-1:0]   req_op0, req_op1;
  logic              alu_load;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_err;
  issue_state_t      dbg_state;

  alu_issue_ctrl #(
    .DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_load(alu_load), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ALU semantics ----------------
  function automatic logic [DATA_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0] op);
    logic [DATA_W-1:0] r;
    int unsigned opi;
    opi = op;
    case (opi)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_MUL)) ? MUL_LAT : ALU_LAT;
  endfunction

  // ALU stand-in: captures on load, shows junk until its latency has run out,
  // so a controller that samples too early sees the wrong value.
  logic [DATA_W-1:0] stub_res  = '0;
  logic [DATA_W-1:0] stub_pend = '0;
  int                stub_cnt  = 0;
  assign alu_result = stub_res;

  always @(posedge clk) begin
    if (alu_load) begin
      stub_pend <= ref_alu(alu_a, alu_b, alu_opcode);
      stub_cnt  <= lat_of(alu_opcode) - 1;
      stub_res  <= (lat_of(alu_opcode) == 1) ? ref_alu(alu_a, alu_b, alu_opcode) : 32'hDEAD_BEEF;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_res <= stub_pend;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // One operation in flight: m_age counts cycles since its accept edge.
  logic [DATA_W-1:0] exp_q[$];
  bit                m_busy = 0;
  int                m_age  = 0;
  bit                m_prio = 0;
  logic [DATA_W-1:0] m_a, m_b;
  logic [OP_W-1:0]   m_op;
  bit                m_id;
  logic [1:0]        mc_rdy;
  bit                mc_rsp;
  int                mc_lat;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_prio = 0;
      exp_q.delete();
    end else begin
      mc_lat = m_busy ? lat_of(m_op) : 0;
      mc_rsp = m_busy && (m_age >= mc_lat + 2);
      if (m_busy)                 mc_rdy = 2'b00;
      else if (req_valid == 2'b11) mc_rdy = m_prio ? 2'b10 : 2'b01;
      else                        mc_rdy = req_valid;

      check("req_ready", req_ready, mc_rdy);
      check("alu_load", alu_load, m_busy && (m_age == 1));
      check("rsp_valid", rsp_valid, mc_rsp);
      if (m_busy && m_age <= mc_lat + 1) begin
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_opcode", alu_opcode, m_op);
      end
      if (mc_rsp && exp_q.size() > 0) begin
        check("rsp_data", rsp_data, exp_q[0]);
        check("rsp_id", rsp_id, m_id);
        check("rsp_err", rsp_err, m_op > OP_MAX);
      end

      if (m_busy) begin
        if (mc_rsp && rsp_ready) begin
          m_busy = 0;
          void'(exp_q.pop_front());
        end else begin
          m_age++;
        end
      end else if (mc_rdy != 2'b00) begin
        m_busy = 1;
        m_age  = 1;
        m_id   = mc_rdy[1];
        m_a    = mc_rdy[1] ? req_a1 : req_a0;
        m_b    = mc_rdy[1] ? req_b1 : req_b0;
        m_op   = mc_rdy[1] ? req_op1 : req_op0;
        exp_q.push_back(ref_alu(m_a, m_b, m_op));
        m_prio = mc_rdy[0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int i, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op);
    if (i == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid[0] = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid[1] = 1'b1;
    end
  endtask

  task automatic random_req(input int i);
    logic [DATA_W-1:0] a, b;
    logic [OP_W-1:0]   op;
    a  = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 100)) : DATA_W'($urandom);
    b  = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 100)) : DATA_W'($urandom);
    op = ($urandom_range(0, 7) == 0) ? OP_W'($urandom_range(6, 63)) : OP_W'($urandom_range(0, 5));
    drive_req(i, a, b, op);
  endtask

  // Returns just after the accept edge (+2) and drops the accepted valid.
  task automatic wait_accept(output int id);
    logic [1:0] hs;
    id = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        id = hs[1] ? 1 : 0;
        break;
      end
    end
    if (id < 0) check("accept_timeout", 1, 0);
    @(posedge clk); #2;
    if (id >= 0) req_valid[id] = 1'b0;
  endtask

  // n = number of negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output logic [DATA_W-1:0] d, output logic id,
                          output logic err, output int n);
    n = 0; d = '0; id = 0; err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = k; d = rsp_data; id = rsp_id; err = rsp_err;
        break;
      end
    end
    if (n == 0) check("rsp_timeout", 1, 0);
    if (rsp_ready) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_alu_load"}, alu_load, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_opcode"}, alu_opcode, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // One complete operation with hand-computed expectations.
  task automatic one_op(input string name, input int req_i, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] exp_d, input int exp_n);
    int id, n;
    logic [DATA_W-1:0] d;
    logic rid, rerr;
    drive_req(req_i, a, b, op);
    wait_accept(id);
    check({name, "_acc_id"}, id, req_i);
    check({name, "_load"}, alu_load, 1);
    wait_rsp(d, rid, rerr, n);
    check({name, "_data"}, d, exp_d);
    check({name, "_id"}, rid, req_i);
    check({name, "_err"}, rerr, 0);
    check({name, "_lat"}, n, exp_n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int id, n;
    logic [DATA_W-1:0] d, d0;
    logic rid, rerr, id0, err0;
    logic [1:0] hs;

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Single ADD
    one_op("add", 0, 32'd10, 32'd5, OP_W'(OP_ADD), 32'd15, 3);

    // Contention from reset priority
    do_reset();
    drive_req(0, 32'd20, 32'd8, OP_W'(OP_SUB));
    drive_req(1, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_W'(OP_AND));
    wait_accept(id);
    check("cont_first_id", id, 0);
    drive_req(0, 32'd1, 32'd2, OP_W'(OP_ADD));
    wait_rsp(d, rid, rerr, n);
    check("cont_sub_data", d, 32'd12);
    check("cont_sub_id", rid, 0);
    wait_accept(id);
    check("cont_second_id", id, 1);
    wait_rsp(d, rid, rerr, n);
    check("cont_and_data", d, 32'h0F00_0F00);
    check("cont_and_id", rid, 1);
    wait_accept(id);
    check("cont_third_id", id, 0);
    wait_rsp(d, rid, rerr, n);
    check("cont_add_data", d, 32'd3);

    // MUL latency and overflow
    one_op("mul_ovf", 1, 32'd65536, 32'd65536, OP_W'(OP_MUL), 32'd0, 4);
    one_op("mul_6x7", 0, 32'd6, 32'd7, OP_W'(OP_MUL), 32'd42, 4);

    // Signed SLT
    one_op("slt_neg", 0, 32'hFFFF_FFFF, 32'd1, OP_W'(OP_SLT), 32'd1, 3);
    one_op("slt_gt", 1, 32'd25, 32'd20, OP_W'(OP_SLT), 32'd0, 3);
    one_op("slt_lt", 0, 32'd15, 32'd20, OP_W'(OP_SLT), 32'd1, 3);

    // Invalid opcode with response backpressure; req1 waits meanwhile
    rsp_ready = 1'b0;
    drive_req(0, 32'hAAAA_AAAA, 32'h0000_1234, 6'b111111);
    wait_accept(id);
    check("inv_acc_id", id, 0);
    drive_req(1, 32'd7, 32'd9, OP_W'(OP_OR));
    wait_rsp(d0, id0, err0, n);
    check("inv_err", err0, 1);
    check("inv_data", d0, 32'd0);
    check("inv_lat", n, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, d0);
      check("bp_id", rsp_id, id0);
      check("bp_err", rsp_err, err0);
      check("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req_ready", req_ready, 2'b00);
    @(posedge clk); #2;
    wait_accept(id);
    check("after_bp_id", id, 1);
    wait_rsp(d, rid, rerr, n);
    check("after_bp_data", d, 32'd15);

    // Reset in the middle of a MUL wait
    drive_req(0, 32'd3, 32'd4, OP_W'(OP_MUL));
    wait_accept(id);
    @(posedge clk); #3;
    check("rst_in_wait_state", dbg_state, ST_WAIT);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    one_op("post_rst", 0, 32'd100, 32'd23, OP_W'(OP_ADD), 32'd123, 3);

    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) random_req(i);
          else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain_idle", dbg_state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that shares the single `alu_operations_five` execute unit between two requesters, such as the ID/EX issue slot and a debug/CSR path. It round-robin arbitrates valid/ready requests and drives the ALU's one-cycle `load` strobe with the latched operands. It then waits the opcode-dependent latency, captures `ALU_result`, and returns it with the requester ID over a backpressured response channel. One operation is in flight at a time.

## Interface
- `DATA_W`, default 32: operand and result width (signed).
- `OP_W`, default 6: opcode width.
- `ALU_LAT`, default 1: wait cycles after `load` for ADD/SUB/AND/OR/SLT and invalid opcodes (≥1).
- `MUL_LAT`, default 2: wait cycles after `load` for MUL (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, one bit per requester.
- `req_ready` out 2: request accepted when `req_valid[i] & req_ready[i]` at a posedge.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in DATA_W each: operands for requesters 0 and 1.
- `req_op0`, `req_op1` in OP_W each: opcodes for requesters 0 and 1.
- `alu_load` out 1: ALU load strobe.
- `alu_a`, `alu_b` out DATA_W: ALU operands (drive ALU `ID_EX_A`, `ID_EX_B`).
- `alu_opcode` out OP_W: ALU opcode.
- `alu_result` in DATA_W: ALU `ALU_result`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out DATA_W: captured result.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_err` out 1: opcode was outside ADD..MUL (0..5).

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - `req_ready` asserts only for the arbiter's grant. Grant is combinational from `req_valid` and the priority pointer.
  - On handshake: latch operands, opcode, ID and err flag, then go to ISSUE.
- **ISSUE**
  - `alu_load`=1 for exactly this cycle.
  - `alu_a`/`alu_b`/`alu_opcode` are driven from the latched registers and held stable from ISSUE through end of WAIT.
  - Load the counter with `MUL_LAT` if opcode==MUL, else `ALU_LAT`. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter is 1, register `alu_result` into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_data`, `rsp_id` and `rsp_err` are held stable until `rsp_valid & rsp_ready`, then go to IDLE.
- **Arbitration** (round-robin, 2-way)
  - If only one requester is valid, it wins.
  - If both are valid, the requester with priority wins.
  - After each grant, priority moves to the other requester.
  - Reset priority is requester 0.
- **Invalid opcode**: forwarded to the ALU unchanged with `ALU_LAT` timing. `rsp_err`=1 and `rsp_data` = whatever the ALU returns (its default).
- **Requesters**: must hold valid, operands and opcode until accepted. An unaccepted valid is never dropped.
- **Arithmetic**: no width change in the controller; overflow and truncation are the ALU's responsibility.

## Timing
- **Reset** (asynchronous, immediate): state=IDLE; `req_ready`=0 when no valid; `alu_load`=0; `alu_a`/`alu_b`/`alu_opcode`=0; `rsp_valid`=0; `rsp_data`=0; `rsp_id`=0; `rsp_err`=0; priority=req0.
- **Latency**:
  - Handshake at posedge T.
  - `alu_load` high during cycle T+1.
  - WAIT covers cycles T+2 … T+1+LAT.
  - `rsp_valid` rises at cycle T+2+LAT.
  - With `ALU_LAT`=1, the response is at T+3.
- **Minimum spacing**: LAT+3 cycles between accepts, since IDLE takes one cycle after the response handshake.
- **`req_ready` outside IDLE**: 0 in ISSUE, WAIT and RESP, including the cycle of the response handshake.
- **Reset mid-operation**: the in-flight operation is discarded and no response is produced. After reset release, the first accept is no earlier than the next posedge.
- **`rsp_ready` held high**: RESP lasts exactly 1 cycle.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5;
  - the FSM state encoding;
  - `OP_MAX`=5.
- `alu_operations_five` imports the same opcode constants.
- One sub-module, `rr_arb2`: inputs `req[1:0]` and an `advance` strobe; outputs a one-hot `gnt[1:0]`; holds the priority flop internally.
- The counter width is derived from max(`ALU_LAT`, `MUL_LAT`).

## Test plan
All scenarios use default parameters and `rsp_ready`=1 unless stated.
- **Single ADD**: req0 valid, A=10, B=5, ADD.
  - `alu_load` pulses at T+1.
  - `rsp_valid` at T+3 with `rsp_data`=15, `rsp_id`=0, `rsp_err`=0.
- **Contention**: req0 SUB 20-8 and req1 AND 0xFF00FF00 & 0x0F0F0F0F asserted together.
  - First response `rsp_data`=12, id 0; second 0x0F000F00, id 1.
  - Re-assert both: req1 is granted first.
- **MUL latency and overflow**: req1 MUL 65536×65536.
  - `rsp_valid` at T+4.
  - `rsp_data`=0, `rsp_id`=1.
  - 6×7 → 42 at T+4.
- **Signed SLT**: 0xFFFFFFFF vs 1 → 1; 25 vs 20 → 0; 15 vs 20 → 1.
- **Invalid opcode and backpressure**: opcode 6'b111111, A=0xAAAAAAAA, with `rsp_ready` low for 4 cycles.
  - `rsp_err`=1; `rsp_valid`, `rsp_data` and `rsp_id` stay stable for all 4 cycles.
  - `req_ready` stays 0 until the response handshake.
- **Reset during WAIT** of a MUL: drive `rst_n` low mid-WAIT.
  - All outputs go to reset values immediately.
  - No `rsp_valid` appears after release.
  - The next request completes normally.
